// File: rtl/wb_cmd_master_pkg.sv
// rtl/wb_cmd_master_pkg.sv - FSM states, response status codes and termination decode for wb_cmd_master
package wb_cmd_master_pkg;

   typedef logic [1:0] state_t;
   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_REQ  = 2'd1;
   localparam state_t S_WAIT = 2'd2;
   localparam state_t S_RSP  = 2'd3;

   typedef logic [1:0] status_t;
   localparam status_t ST_OK      = 2'b00;
   localparam status_t ST_ERR     = 2'b01;
   localparam status_t ST_RTY     = 2'b10;
   localparam status_t ST_TIMEOUT = 2'b11;

   // Coinciding terminations resolve err over rty over ack.
   function automatic status_t term_status(input logic err, input logic rty);
      status_t st;
      if (err) begin
         st = ST_ERR;
      end else if (rty) begin
         st = ST_RTY;
      end else begin
         st = ST_OK;
      end
      return st;
   endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// rtl/wb_timeout_cnt.sv - saturating cycle counter flagging the last cycle before a forced bus abort
module wb_timeout_cnt #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != LIMIT)) begin
         count <= count + 1'b1;
      end
   end

   assign expired = en && (count == LIMIT);

endmodule

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - single-outstanding Wishbone pipelined initiator behind cmd/rsp valid-ready ports
module wb_cmd_master
   import wb_cmd_master_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic                    cmd_we_i,
   input  logic [ADDR_WIDTH-1:0]   cmd_adr_i,
   input  logic [DATA_WIDTH-1:0]   cmd_dat_i,
   input  logic [DATA_WIDTH/8-1:0] cmd_sel_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_dat_o,
   output logic [1:0]              rsp_status_o,
   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   output logic                    wb_we_o,
   output logic [ADDR_WIDTH-1:0]   wb_adr_o,
   output logic [DATA_WIDTH/8-1:0] wb_sel_o,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic                    wb_ack_i,
   input  logic                    wb_err_i,
   input  logic                    wb_rty_i,
   input  logic                    wb_stall_i
);

   state_t  state;
   logic    take;
   logic    term_seen;
   logic    tmo_clr;
   logic    tmo_en;
   logic    expired;
   status_t term_code;

   // Terminations only count once the request has been taken (or in WAIT).
   assign take      = (state == S_REQ) && !wb_stall_i;
   assign term_seen = (take || (state == S_WAIT)) && (wb_ack_i || wb_err_i || wb_rty_i);
   assign term_code = term_status(wb_err_i, wb_rty_i);
   assign tmo_clr   = (state == S_IDLE);
   assign tmo_en    = (state == S_REQ) || (state == S_WAIT);

   wb_timeout_cnt #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout_cnt (
      .clk     (clk_i),
      .rst_n   (rst_n_i),
      .clr     (tmo_clr),
      .en      (tmo_en),
      .expired (expired)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state        <= S_IDLE;
         cmd_ready_o  <= 1'b1;
         rsp_valid_o  <= 1'b0;
         rsp_status_o <= ST_OK;
         rsp_dat_o    <= '0;
         wb_cyc_o     <= 1'b0;
         wb_stb_o     <= 1'b0;
         wb_we_o      <= 1'b0;
         wb_adr_o     <= '0;
         wb_sel_o     <= '0;
         wb_dat_o     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid_i && cmd_ready_o) begin
                  wb_we_o     <= cmd_we_i;
                  wb_adr_o    <= cmd_adr_i;
                  wb_dat_o    <= cmd_dat_i;
                  wb_sel_o    <= cmd_sel_i;
                  wb_cyc_o    <= 1'b1;
                  wb_stb_o    <= 1'b1;
                  cmd_ready_o <= 1'b0;
                  state       <= S_REQ;
               end
            end
            S_REQ, S_WAIT: begin
               if (term_seen) begin
                  wb_cyc_o     <= 1'b0;
                  wb_stb_o     <= 1'b0;
                  rsp_valid_o  <= 1'b1;
                  rsp_status_o <= term_code;
                  rsp_dat_o    <= ((term_code == ST_OK) && !wb_we_o) ? wb_dat_i : '0;
                  state        <= S_RSP;
               end else if (expired) begin
                  wb_cyc_o     <= 1'b0;
                  wb_stb_o     <= 1'b0;
                  rsp_valid_o  <= 1'b1;
                  rsp_status_o <= ST_TIMEOUT;
                  rsp_dat_o    <= '0;
                  state        <= S_RSP;
               end else if (take) begin
                  wb_stb_o <= 1'b0;
                  state    <= S_WAIT;
               end
            end
            S_RSP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  cmd_ready_o <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - randomized bench for wb_cmd_master against a register-bank slave and reference model
module tb_wb_cmd_master;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int TMO = 16;

   localparam int T_ACK     = 0;
   localparam int T_ERR     = 1;
   localparam int T_RTY     = 2;
   localparam int T_ERR_ACK = 3;
   localparam int T_NONE    = 4;
   localparam int T_RTY_ACK = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_we = 1'b0;
   logic [AW-1:0] cmd_adr = '0;
   logic [DW-1:0] cmd_dat = '0;
   logic [SW-1:0] cmd_sel = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_dat;
   logic [1:0]    rsp_status;
   logic          wb_cyc, wb_stb, wb_we;
   logic [AW-1:0] wb_adr;
   logic [SW-1:0] wb_sel;
   logic [DW-1:0] wb_dat_m;
   logic [DW-1:0] wb_dat_s = '0;
   logic          wb_ack = 1'b0, wb_err = 1'b0, wb_rty = 1'b0, wb_stall = 1'b0;

   int checks = 0;
   int failures = 0;

   int plan_stall = 0, plan_wait = 0, plan_term = T_ACK;
   bit stray_en = 1'b0;
   int s_stall_cnt = 0, s_wait_cnt = 0;
   int mon_stb = 0, mon_cyc = 0, mon_takes = 0, mon_bad = 0;
   logic [AW-1:0] exp_adr = '0;
   logic [DW-1:0] exp_dat = '0;
   logic [SW-1:0] exp_sel = '0;
   logic          exp_we = 1'b0;
   logic [DW-1:0] slave_mem [16];
   logic [DW-1:0] ref_mem [16];

   wb_cmd_master #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .TIMEOUT   (TMO)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready),
      .cmd_we_i     (cmd_we),
      .cmd_adr_i    (cmd_adr),
      .cmd_dat_i    (cmd_dat),
      .cmd_sel_i    (cmd_sel),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_dat_o    (rsp_dat),
      .rsp_status_o (rsp_status),
      .wb_cyc_o     (wb_cyc),
      .wb_stb_o     (wb_stb),
      .wb_we_o      (wb_we),
      .wb_adr_o     (wb_adr),
      .wb_sel_o     (wb_sel),
      .wb_dat_o     (wb_dat_m),
      .wb_dat_i     (wb_dat_s),
      .wb_ack_i     (wb_ack),
      .wb_err_i     (wb_err),
      .wb_rty_i     (wb_rty),
      .wb_stall_i   (wb_stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] dat,
                                           input logic [SW-1:0] sel);
      logic [DW-1:0] r = old;
      for (int b = 0; b < SW; b++) if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
      return r;
   endfunction

   task automatic drive_term();
      int idx = int'(wb_adr[5:2]);
      wb_ack = (plan_term == T_ACK) || (plan_term == T_ERR_ACK) || (plan_term == T_RTY_ACK);
      wb_err = (plan_term == T_ERR) || (plan_term == T_ERR_ACK);
      wb_rty = (plan_term == T_RTY) || (plan_term == T_RTY_ACK);
      if (wb_ack && !wb_we) wb_dat_s = slave_mem[idx];
      if ((plan_term == T_ACK) && wb_we) slave_mem[idx] = merge(slave_mem[idx], wb_dat_m, wb_sel);
   endtask

   // Register-bank slave: stalls, waits and terminates as the current plan says.
   always @(posedge clk) begin
      #1;
      wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0; wb_stall = 1'b0;
      wb_dat_s = $urandom;
      if (!rst_n || !wb_cyc) begin
         s_stall_cnt = 0;
         s_wait_cnt = 0;
         if (stray_en && rst_n) begin
            wb_ack = 1'($urandom_range(0, 1));
            wb_err = 1'($urandom_range(0, 1));
            wb_rty = 1'($urandom_range(0, 1));
         end
      end else if (wb_stb) begin
         mon_stb++;
         mon_cyc++;
         if (wb_adr !== exp_adr || wb_dat_m !== exp_dat || wb_sel !== exp_sel || wb_we !== exp_we)
            mon_bad++;
         if (s_stall_cnt < plan_stall) begin
            wb_stall = 1'b1;
            s_stall_cnt++;
         end else begin
            mon_takes++;
            s_wait_cnt = 0;
            if (plan_wait == 0) drive_term();
         end
      end else begin
         mon_cyc++;
         s_wait_cnt++;
         if (s_wait_cnt == plan_wait) drive_term();
      end
   end

   task automatic run_txn(input logic we, input logic [3:0] idx, input logic [DW-1:0] dat,
                          input logic [SW-1:0] sel, input int stall, input int waitc,
                          input int term, input int bp, input bit hold_next, input string name);
      bit            to;
      int            c, exp_stb, exp_takes, lat, bp_bad, n;
      logic [1:0]    exp_st;
      logic [DW-1:0] exp_d;

      to        = (term == T_NONE) || (stall + waitc > TMO - 1);
      c         = to ? TMO - 1 : stall + waitc;
      exp_stb   = (stall + 1 < TMO) ? stall + 1 : TMO;
      exp_takes = (stall < TMO) ? 1 : 0;
      if (to) exp_st = 2'b11;
      else if (term == T_ACK) exp_st = 2'b00;
      else if (term == T_ERR || term == T_ERR_ACK) exp_st = 2'b01;
      else exp_st = 2'b10;
      exp_d = (exp_st == 2'b00 && !we) ? ref_mem[idx] : '0;
      if (exp_st == 2'b00 && we) ref_mem[idx] = merge(ref_mem[idx], dat, sel);

      plan_stall = stall; plan_wait = waitc; plan_term = term;
      exp_adr = AW'({idx, 2'b00}); exp_dat = dat; exp_sel = sel; exp_we = we;
      mon_stb = 0; mon_cyc = 0; mon_takes = 0; mon_bad = 0;
      cmd_we = we; cmd_adr = exp_adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;

      n = 0;
      while (!cmd_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, ".cmd_ready"}, cmd_ready, 1'b1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;

      lat = 0;
      while (!rsp_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check({name, ".latency"}, lat, c + 1);
      check({name, ".status"}, rsp_status, exp_st);
      check({name, ".rdata"}, rsp_dat, exp_d);
      check({name, ".cyc_len"}, mon_cyc, c + 1);
      check({name, ".stb_len"}, mon_stb, exp_stb);
      check({name, ".takes"}, mon_takes, exp_takes);
      check({name, ".req_stable"}, mon_bad, 0);
      check({name, ".cyc_off"}, wb_cyc, 1'b0);

      bp_bad = 0;
      cmd_valid = hold_next;
      for (int i = 0; i < bp; i++) begin
         @(posedge clk); #1;
         if (!rsp_valid || rsp_status !== exp_st || rsp_dat !== exp_d || cmd_ready || wb_cyc)
            bp_bad++;
      end
      check({name, ".rsp_hold"}, bp_bad, 0);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check({name, ".rsp_done"}, rsp_valid, 1'b0);
      check({name, ".ready_back"}, cmd_ready, 1'b1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         slave_mem[i] = '0;
         ref_mem[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      check("reset.cyc_stb", {wb_cyc, wb_stb, wb_we}, 3'b000);
      check("reset.rsp", {rsp_valid, rsp_status}, 3'b000);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("reset.cmd_ready", cmd_ready, 1'b1);
      check("reset.rsp_dat", rsp_dat, '0);
      check("reset.wb_bus", {wb_adr, wb_sel, wb_dat_m}, '0);

      run_txn(1'b1, 4'd0, 32'hDEADBEEF, 4'hF, 0, 0, T_ACK, 0, 1'b0, "t1_wr");
      run_txn(1'b0, 4'd0, 32'h0, 4'hF, 0, 0, T_ACK, 0, 1'b0, "t1_rd");
      run_txn(1'b1, 4'd1, 32'h1234_5678, 4'hF, 4, 0, T_ACK, 0, 1'b0, "t2_wr");
      run_txn(1'b0, 4'd1, 32'h0, 4'hF, 4, 2, T_ACK, 1, 1'b0, "t2_rd");
      run_txn(1'b0, 4'd0, 32'h0, 4'hF, 0, 0, T_ERR_ACK, 0, 1'b0, "t3");
      stray_en = 1'b1;
      run_txn(1'b0, 4'd2, 32'h0, 4'hF, 0, 0, T_NONE, 6, 1'b0, "t4");
      stray_en = 1'b0;
      run_txn(1'b0, 4'd0, 32'h0, 4'hF, 5, 10, T_ACK, 0, 1'b0, "tmo_edge_ok");
      run_txn(1'b1, 4'd3, 32'hCAFE_F00D, 4'hF, 5, 11, T_ACK, 0, 1'b0, "tmo_edge_to");
      run_txn(1'b0, 4'd3, 32'h0, 4'hF, 20, 0, T_ACK, 0, 1'b0, "tmo_stall");
      run_txn(1'b1, 4'd4, 32'hA5A5_0F0F, 4'h5, 0, 1, T_ACK, 10, 1'b1, "t5a");
      run_txn(1'b0, 4'd4, 32'h0, 4'hF, 0, 0, T_ACK, 0, 1'b0, "t5b");

      plan_stall = 0; plan_wait = 10; plan_term = T_ACK;
      mon_bad = 0;
      exp_adr = AW'(12); exp_we = 1'b0; exp_sel = 4'hF; exp_dat = '0;
      cmd_we = 1'b0; cmd_adr = exp_adr; cmd_sel = 4'hF; cmd_dat = '0; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("t6.in_wait", {wb_cyc, wb_stb}, 2'b10);
      #2 rst_n = 1'b0;
      #1;
      check("t6.cyc_stb", {wb_cyc, wb_stb, wb_we}, 3'b000);
      check("t6.rsp", {rsp_valid, rsp_status, rsp_dat}, '0);
      check("t6.wb_bus", {wb_adr, wb_sel, wb_dat_m}, '0);
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("t6.cmd_ready", cmd_ready, 1'b1);
      run_txn(1'b0, 4'd0, 32'h0, 4'hF, 1, 1, T_ACK, 0, 1'b0, "t6_after");

      for (int i = 0; i < 60; i++) begin
         logic          we;
         logic [3:0]    idx;
         logic [DW-1:0] dat;
         logic [SW-1:0] sel;
         int            stall, waitc, term, r, bp;
         bit            hold;
         we    = 1'($urandom_range(0, 1));
         idx   = 4'($urandom_range(0, 15));
         dat   = $urandom;
         sel   = SW'($urandom_range(0, 15));
         stall = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 4));
         waitc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 18)) : int'($urandom_range(0, 4));
         r     = int'($urandom_range(0, 9));
         term  = (r < 5) ? T_ACK : (r == 5) ? T_ERR : (r == 6) ? T_RTY :
                 (r == 7) ? T_ERR_ACK : (r == 8) ? T_RTY_ACK : T_NONE;
         bp    = int'($urandom_range(0, 3));
         hold  = (i < 59) && ($urandom_range(0, 3) == 0);
         stray_en = ($urandom_range(0, 3) == 0);
         run_txn(we, idx, dat, sel, stall, waitc, term, bp, hold, $sformatf("rnd%0d", i));
      end
      stray_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
